// File: rtl/operand_fwd_ctrl_if.sv
// rtl/operand_fwd_ctrl_if.sv - issue/select bundle between ID stage and operand forwarding controller (FWD_STATS_EN adds stats)
interface operand_fwd_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              issue_valid;
    logic              issue_we;
    logic              issue_load;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] issue_rs_a;
    logic [REG_AW-1:0] issue_rs_b;
    logic              stall;
    logic              flush;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              ex_valid;
    logic              hazard;
`ifdef FWD_STATS_EN
    logic [15:0]       fwd_count;
    logic [15:0]       bubble_count;
`endif

    // ID/IF side: presents instructions, consumes selects and stall request
    modport master (
        output issue_valid, issue_we, issue_load, issue_rd, issue_rs_a, issue_rs_b,
        output stall, flush,
        input  sel_a, sel_b, ex_valid, hazard
`ifdef FWD_STATS_EN
        , input fwd_count, bubble_count
`endif
    );

    // Controller side
    modport slave (
        input  issue_valid, issue_we, issue_load, issue_rd, issue_rs_a, issue_rs_b,
        input  stall, flush,
        output sel_a, sel_b, ex_valid, hazard
`ifdef FWD_STATS_EN
        , output fwd_count, bubble_count
`endif
    );
endinterface

// File: rtl/operand_fwd_ctrl.sv
// rtl/operand_fwd_ctrl.sv - EX operand forwarding select and load-use bubble controller (optional FWD_STATS_EN counters)
module operand_fwd_ctrl #(
    parameter int REG_AW   = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    operand_fwd_ctrl_if.slave  fwd
);

    // Shadow pipeline: s1 = EX, s2 = MEM, s3 = WB.
    // The load flag only matters while the producer sits in EX (its data is
    // not ready until end of MEM), so it is kept for s1 only.
    logic              r_s1_valid, r_s1_we, r_s1_load;
    logic [REG_AW-1:0] r_s1_rd;
    logic              r_s2_valid, r_s2_we;
    logic [REG_AW-1:0] r_s2_rd;
    logic              r_s3_valid, r_s3_we;
    logic [REG_AW-1:0] r_s3_rd;

    logic [1:0]        r_sel_a, r_sel_b;
    logic              r_ex_valid;

    logic              w_s1_live, w_s2_live, w_s3_live;
    logic              w_hazard;
    logic              w_advance;
    logic              w_issue_take;
    logic [1:0]        w_sel_a, w_sel_b;

    function automatic logic is_live(input logic v, input logic we, input logic [REG_AW-1:0] rd);
        return v && we && !(ZERO_REG && (rd == '0));
    endfunction

    // Youngest in-flight producer wins; register 0 never forwards
    function automatic logic [1:0] pick_sel(
        input logic              valid,
        input logic [REG_AW-1:0] rs,
        input logic              l1, input logic [REG_AW-1:0] rd1,
        input logic              l2, input logic [REG_AW-1:0] rd2,
        input logic              l3, input logic [REG_AW-1:0] rd3
    );
        if (!valid || (ZERO_REG && (rs == '0))) return 2'd0;
        if (l1 && (rs == rd1)) return 2'd1;
        if (l2 && (rs == rd2)) return 2'd2;
        if (l3 && (rs == rd3)) return 2'd3;
        return 2'd0;
    endfunction

    assign w_s1_live = is_live(r_s1_valid, r_s1_we, r_s1_rd);
    assign w_s2_live = is_live(r_s2_valid, r_s2_we, r_s2_rd);
    assign w_s3_live = is_live(r_s3_valid, r_s3_we, r_s3_rd);

    assign w_hazard  = fwd.issue_valid && w_s1_live && r_s1_load &&
                       ((fwd.issue_rs_a == r_s1_rd) || (fwd.issue_rs_b == r_s1_rd));
    assign w_advance = !fwd.stall && !w_hazard;
    assign w_issue_take = w_advance && !fwd.flush;

    // Select values for the instruction in ID, from the pre-edge shadow slots
    always_comb begin
        w_sel_a = 2'd0;
        w_sel_b = 2'd0;
        w_sel_a = pick_sel(fwd.issue_valid, fwd.issue_rs_a,
                           w_s1_live, r_s1_rd, w_s2_live, r_s2_rd, w_s3_live, r_s3_rd);
        w_sel_b = pick_sel(fwd.issue_valid, fwd.issue_rs_b,
                           w_s1_live, r_s1_rd, w_s2_live, r_s2_rd, w_s3_live, r_s3_rd);
    end

    // Shadow pipeline shift; s1 takes the issue or a bubble, everything holds on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0; r_s1_we <= 1'b0; r_s1_load <= 1'b0; r_s1_rd <= '0;
            r_s2_valid <= 1'b0; r_s2_we <= 1'b0; r_s2_rd <= '0;
            r_s3_valid <= 1'b0; r_s3_we <= 1'b0; r_s3_rd <= '0;
        end else if (!fwd.stall) begin
            r_s3_valid <= r_s2_valid; r_s3_we <= r_s2_we; r_s3_rd <= r_s2_rd;
            r_s2_valid <= r_s1_valid; r_s2_we <= r_s1_we; r_s2_rd <= r_s1_rd;
            if (w_issue_take) begin
                r_s1_valid <= fwd.issue_valid;
                r_s1_we    <= fwd.issue_we;
                r_s1_load  <= fwd.issue_load;
                r_s1_rd    <= fwd.issue_rd;
            end else begin
                r_s1_valid <= 1'b0;
                r_s1_we    <= 1'b0;
                r_s1_load  <= 1'b0;
                r_s1_rd    <= '0;
            end
        end
    end

    // Registered mux selects and EX valid, one cycle ahead of operand use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_a    <= 2'd0;
            r_sel_b    <= 2'd0;
            r_ex_valid <= 1'b0;
        end else if (!fwd.stall) begin
            if (w_issue_take) begin
                r_sel_a    <= w_sel_a;
                r_sel_b    <= w_sel_b;
                r_ex_valid <= fwd.issue_valid;
            end else begin
                r_sel_a    <= 2'd0;
                r_sel_b    <= 2'd0;
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign fwd.sel_a    = r_sel_a;
    assign fwd.sel_b    = r_sel_b;
    assign fwd.ex_valid = r_ex_valid;
    assign fwd.hazard   = w_hazard;

`ifdef FWD_STATS_EN
    logic [15:0] r_fwd_count;
    logic [15:0] r_bubble_count;

    // Saturating counters of forwarded issues and load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_count    <= 16'd0;
            r_bubble_count <= 16'd0;
        end else begin
            if (w_issue_take && ((w_sel_a != 2'd0) || (w_sel_b != 2'd0)) &&
                (r_fwd_count != 16'hFFFF))
                r_fwd_count <= r_fwd_count + 16'd1;
            if (!fwd.stall && w_hazard && (r_bubble_count != 16'hFFFF))
                r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign fwd.fwd_count    = r_fwd_count;
    assign fwd.bubble_count = r_bubble_count;
`endif

endmodule
